// File: rtl/adc_spi_master_if.sv
// Control-side bus of the ADS4128 SPI engine: command strobe, frame fields, status and readback.
// master = ADC control register block, slave = SPI engine.
interface adc_spi_master_if;
  logic       start_i;
  logic       rw_i;
  logic [7:0] addr_i;
  logic [7:0] wdata_i;
  logic       busy_o;
  logic       done_o;
  logic [7:0] rdata_o;

  modport master (output start_i, rw_i, addr_i, wdata_i, input busy_o, done_o, rdata_o);
  modport slave  (input start_i, rw_i, addr_i, wdata_i, output busy_o, done_o, rdata_o);
endinterface

// File: rtl/adc_spi_master.sv
// ADS4128 SPI master: one 16-bit addr/data frame per start; done 1+2*pSEN_SETUP+32*pCLKDIV cycles after start.
// start_i ignored while busy and in the done cycle (no queueing); ADC_SPI_AUTOINIT_EN adds a post-reset soft-reset frame.
module adc_spi_master #(
  parameter int unsigned pCLKDIV    = 4,
  parameter int unsigned pSEN_SETUP = 2
) (
  input  logic            clk_usb,
  input  logic            reset_i,
  adc_spi_master_if.slave ctrl,
  output logic            ADC_SEN,
  output logic            ADC_SCLK,
  output logic            ADC_SDATA,
  input  logic            ADC_OVR_SDOUT
);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLD} state_t;

  localparam logic [7:0] CLKDIV_M1 = 8'(pCLKDIV - 1);
  localparam logic [7:0] SETUP_M1  = 8'(pSEN_SETUP - 1);

  state_t      state, state_nxt;
  logic [7:0]  phase_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        rd_frame;
  logic [7:0]  cap;
  logic        done_q;
  logic [7:0]  rdata_q;
  logic        init_pend;
  logic        phase_end;
  logic        accept;
  logic        launch_init;

`ifdef ADC_SPI_AUTOINIT_EN
  // Stays set for the whole init frame so its done pulse can be suppressed.
  always_ff @(posedge clk_usb) begin
    if (reset_i)
      init_pend <= 1'b1;
    else if (state == HOLD && phase_end)
      init_pend <= 1'b0;
  end
`else
  assign init_pend = 1'b0;
`endif

  assign launch_init = (state == IDLE) && init_pend;
  assign accept      = (state == IDLE) && ctrl.start_i && !done_q && !init_pend;

  always_ff @(posedge clk_usb) begin
    if (reset_i) begin
      state     <= IDLE;
      phase_cnt <= 8'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 16'd0;
      rd_frame  <= 1'b0;
      cap       <= 8'd0;
      done_q    <= 1'b0;
      rdata_q   <= 8'd0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      phase_cnt <= (state_nxt != state || state == IDLE) ? 8'd0 : phase_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (launch_init) begin
            shreg    <= 16'h0002;
            rd_frame <= 1'b0;
            bit_cnt  <= 4'd0;
          end else if (accept) begin
            shreg    <= {ctrl.addr_i, ctrl.rw_i ? 8'h00 : ctrl.wdata_i};
            rd_frame <= ctrl.rw_i;
            bit_cnt  <= 4'd0;
          end
        end
        LOW: begin
          if (phase_end) begin
            shreg <= {shreg[14:0], 1'b0};
            // Readback occupies the data half of the frame (bit_cnt 8..15).
            if (rd_frame && bit_cnt[3])
              cap <= {cap[6:0], ADC_OVR_SDOUT};
          end
        end
        HIGH: begin
          if (phase_end)
            bit_cnt <= bit_cnt + 4'd1;
        end
        HOLD: begin
          if (phase_end) begin
            done_q <= !init_pend;
            if (rd_frame)
              rdata_q <= cap;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_end    = 1'b0;
    ADC_SEN      = 1'b1;
    ADC_SCLK     = 1'b1;
    ADC_SDATA    = 1'b0;
    ctrl.busy_o  = 1'b0;
    ctrl.done_o  = done_q;
    ctrl.rdata_o = rdata_q;

    case (state)
      SETUP, HOLD: phase_end = (phase_cnt == SETUP_M1);
      LOW, HIGH:   phase_end = (phase_cnt == CLKDIV_M1);
      default:     phase_end = 1'b0;
    endcase

    case (state)
      IDLE:  if (accept || launch_init) state_nxt = SETUP;
      SETUP: if (phase_end) state_nxt = LOW;
      LOW:   if (phase_end) state_nxt = HIGH;
      HIGH:  if (phase_end) state_nxt = (bit_cnt == 4'd15) ? HOLD : LOW;
      HOLD:  if (phase_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (state != IDLE) begin
      ADC_SEN     = 1'b0;
      ctrl.busy_o = 1'b1;
    end
    if (state == LOW)
      ADC_SCLK = 1'b0;
    if (state == SETUP || state == LOW || state == HIGH)
      ADC_SDATA = shreg[15];
  end

endmodule

// File: doc/adc_spi_master.md
Name: adc_spi_master

Overview:
- Hardware SPI engine for the ADS4128 serial configuration port. It replaces per-edge software bit-banging with single-command register transfers.
- Sits between the ADC control register block, which supplies address, data and a start strobe, and the ADC serial pins (SEN, SCLK, SDATA, OVR_SDOUT).
- Generates one complete 16-bit frame per command: 8 address bits then 8 data bits, MSB first. Read frames capture 8 bits from SDOUT.

Parameters:
- pCLKDIV, 4: length of each SCLK phase (high or low) in clk_usb cycles. Legal range 1..255.
- pSEN_SETUP, 2: clk_usb cycles SEN is held low before the first SCLK fall and after the last SCLK rise. Legal range 1..255.

Ports:
- clk_usb  in  1  system clock; only clock in the block
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  command strobe; sampled only while idle
- rw_i  in  1  1 = read frame, 0 = write frame; latched with start_i
- addr_i  in  8  ADC register address; latched with start_i
- wdata_i  in  8  write data; latched with start_i, ignored for reads
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at end of transfer
- rdata_o  out  8  last read result
- ADC_SEN  out  1  serial enable, active low
- ADC_SCLK  out  1  serial clock, idles high
- ADC_SDATA  out  1  serial data to ADC
- ADC_OVR_SDOUT  in  1  serial readback data from ADC

Behaviour:
- Reset values: ADC_SEN=1, ADC_SCLK=1, ADC_SDATA=0, busy_o=0, done_o=0, rdata_o=0x00. Reset aborts any transfer immediately; no partial frame is completed afterwards.
- Frame definition: frame[15:0] = {addr_i, rw_i ? 8'h00 : wdata_i}, latched at start. The read/write distinction is carried only by rw_i. The caller sets the ADS4128 READOUT bit beforehand.
- States: IDLE, SETUP, LOW, HIGH, HOLD. Use one phase counter (8 bits) and one bit counter (4 bits).
- IDLE -> SETUP: on start_i=1 at edge T.
  - SEN=0 and busy_o=1 from T+1.
  - SCLK=1, SDATA=frame[15] throughout SETUP.
  - SETUP lasts pSEN_SETUP cycles, then goes to LOW.
- LOW: SCLK=0 for pCLKDIV cycles; the ADC latches SDATA on this falling edge.
  - On the last LOW cycle of a read frame, for bits 7..0, shift ADC_OVR_SDOUT into the capture register LSB (shift left).
  - Then go to HIGH.
- HIGH: SCLK=1 for pCLKDIV cycles; SDATA=next frame bit (0 after bit 0).
  - After 16 LOW/HIGH pairs, go to HOLD.
  - Otherwise return to LOW.
- HOLD: SEN=0, SCLK=1, SDATA=0 for pSEN_SETUP cycles, then IDLE.
- Exit to IDLE, same edge: SEN=1, busy_o=0, done_o=1 for exactly one cycle.
  - If read, rdata_o is loaded from the capture register on this edge.
  - Write frames leave rdata_o unchanged.
- Latency: done_o is high during cycle T+1+2*pSEN_SETUP+32*pCLKDIV, which is T+133 with defaults.
- start_i while busy_o=1 is ignored; no queueing, and the latched frame is unaffected.
- start_i in the same cycle done_o is high is ignored. The earliest accepted restart is the following cycle, so SEN is high for at least 1 cycle between frames.
- rw_i/addr_i/wdata_i changes after acceptance have no effect.

Optional Feature:
- Macro ADC_SPI_AUTOINIT_EN.
- Defined:
  - After reset deasserts, the block runs one write frame on its own: addr 0x00, data 0x02, the ADS4128 software reset.
  - busy_o=1 throughout; start_i is ignored until it finishes.
  - done_o is NOT pulsed for this frame.
  - Adds a one-bit "init pending" flag, set by reset_i.
- Undefined: the block stays in IDLE after reset until start_i.

Test Plan:
- Write 0xAA to addr 0x55, defaults -> SDATA sampled at each SCLK fall = 0101_0101_1010_1010. Exactly 16 SCLK falls; SEN low from T+1; done_o single pulse at T+133; busy_o 0 at T+133; rdata_o stays 0x00.
- Read addr 0x03 while the ADC model drives 0xC5 (bit changes after each SCLK fall) -> SDATA = 0x03 then 0x00; rdata_o=0xC5 at the done_o edge, held through a subsequent write frame.
- start_i pulsed at T+10 and T+60 during a transfer, and again in the done_o cycle -> all ignored, frame unchanged. A start_i in the cycle after done_o is accepted and SEN falls one cycle later.
- reset_i asserted at T+40 mid-frame -> next cycle SEN=1, SCLK=1, SDATA=0, busy_o=0, no done_o. A new start_i after reset completes normally.
- pCLKDIV=1, pSEN_SETUP=1, write addr 0xFF data 0x00 -> done_o at T+35; SCLK phases exactly 1 cycle each.
- ADC_SPI_AUTOINIT_EN defined -> after reset release, frame 0x0002 is shifted with busy_o=1 and no done_o. start_i during it is ignored; the first user frame starts only after SEN returns high.
